btn_ctrl: RTL

- Front-end control stage that feeds the cnt500 stopwatch counter's start/stop inputs.
- Takes two raw, bouncy, asynchronous push-buttons and synchronises and debounces each one.
- Turns each debounced press into a single-cycle start or stop pulse, gated by a run/stop state machine.
- Also exports a running flag for LEDs and display logic.

---
 rtl/btn_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/btn_ctrl.sv
// Two-button front end for the cnt500 stopwatch: sync, debounce, edge detect, run/stop FSM.
// Define TOGGLE_BTN_EN to make btn_start toggle between start and stop.
module btn_ctrl #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic btn_start,
  input  logic btn_stop,
  output logic start,
  output logic stop,
  output logic running
);

  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);

  typedef enum logic {STOPPED, RUN} state_e;

  // Bit 0 carries btn_start, bit 1 carries btn_stop.
  logic [1:0]     s1_q, s2_q;
  logic [1:0]     db_q, db_d, db_dly_q;
  logic [DBW-1:0] cnt_q [2];
  logic [DBW-1:0] cnt_d [2];
  logic [1:0]     rise;
  logic           toggle_stop;

  state_e state_q;
  logic   start_q, stop_q, running_q;

  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DBW'(DB_CYCLES - 1)) db_d[i] = s2_q[i];
        else                                 cnt_d[i] = cnt_q[i] + DBW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q     <= {btn_stop, btn_start};
      s2_q     <= s1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Press events are combinational off registered levels so the pulse lands DB_CYCLES+3 edges after the raw rise.
  assign rise = db_q & ~db_dly_q;

`ifdef TOGGLE_BTN_EN
  assign toggle_stop = rise[0];
`else
  assign toggle_stop = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= STOPPED;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      case (state_q)
        STOPPED: begin
          // A concurrent stop press wins, so nothing happens here.
          if (rise[0] && !rise[1]) begin
            start_q   <= 1'b1;
            running_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (rise[1] || toggle_stop) begin
            stop_q    <= 1'b1;
            running_q <= 1'b0;
            state_q   <= STOPPED;
          end
        end
        default: begin
          state_q   <= STOPPED;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign start   = start_q;
  assign stop    = stop_q;
  assign running = running_q;

endmodule
